uart_tx_param: RTL and testbench

UART_TX_PARAM -- requirements
Module: uart_tx_param

---
 rtl/uart_pkg.sv | 21 ++
 rtl/sync_fifo.sv | 62 ++++++
 rtl/uart_tx_param.sv | 171 +++++++++++++++++
 tb/tb_uart_tx_param.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared encodings and helpers for the UART transmitter
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } tx_state_e;

    localparam int PARITY_NONE = 0;
    localparam int PARITY_EVEN = 1;
    localparam int PARITY_ODD  = 2;

    // Narrow words are zero-extended by the caller; zeros do not change the XOR.
    function automatic logic parity_bit(input logic [7:0] data, input int mode);
        return (^data) ^ (mode == PARITY_ODD);
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - single-clock FIFO with first-word-fall-through read data
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     wr_valid,
    input  logic [WIDTH-1:0]         wr_data,
    output logic                     wr_ready,
    input  logic                     rd_en,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             push, pop;

    assign wr_ready = (count_q != (AW+1)'(DEPTH));
    assign empty    = (count_q == '0);
    assign level    = count_q;
    assign rd_data  = mem_q[rd_ptr_q];
    assign push     = wr_valid && wr_ready;
    assign pop      = rd_en && !empty;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) wr_ptr_d = wr_ptr_q + AW'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
        case ({push, pop})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= wr_data;
    end

endmodule

// File: rtl/uart_tx_param.sv
// rtl/uart_tx_param.sv - parameterised UART transmitter with transmit FIFO
module uart_tx_param
    import uart_pkg::*;
#(
    parameter int CLOCK_FREQ   = 50_000_000,
    parameter int BAUD         = 9600,
    parameter int CLKS_PER_BIT = CLOCK_FREQ / BAUD,
    parameter int DATA_BITS    = 8,
    parameter int PARITY       = PARITY_NONE,
    parameter int STOP_BITS    = 1,
    parameter int FIFO_DEPTH   = 16
) (
    input  logic                          Clk,
    input  logic                          Reset,
    input  logic [DATA_BITS-1:0]          in_data,
    input  logic                          in_valid,
    output logic                          in_ready,
    output logic                          uart_tx,
    output logic                          busy,
    output logic                          tx_done,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int BIT_W = 3;

    tx_state_e            state_q, state_d;
    logic [CNT_W-1:0]     baud_q, baud_d;
    logic [BIT_W-1:0]     bit_q, bit_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 parity_q, parity_d;
    logic                 tx_q, tx_d;
    logic                 done_q, done_d;
    logic                 busy_q, busy_d;

    logic                 fifo_pop;
    logic                 fifo_empty;
    logic [DATA_BITS-1:0] fifo_rd_data;
    logic                 bit_end;

    sync_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (Clk),
        .reset    (Reset),
        .wr_valid (in_valid),
        .wr_data  (in_data),
        .wr_ready (in_ready),
        .rd_en    (fifo_pop),
        .rd_data  (fifo_rd_data),
        .empty    (fifo_empty),
        .level    (fifo_level)
    );

    assign bit_end = (baud_q == CNT_W'(CLKS_PER_BIT - 1));
    assign uart_tx = tx_q;
    assign tx_done = done_q;
    assign busy    = busy_q;

    always_comb begin
        state_d  = state_q;
        baud_d   = baud_q + CNT_W'(1);
        bit_d    = bit_q;
        shift_d  = shift_q;
        parity_d = parity_q;
        tx_d     = tx_q;
        done_d   = 1'b0;
        fifo_pop = 1'b0;
        busy_d   = (state_q != ST_IDLE) || !fifo_empty;

        case (state_q)
            ST_IDLE: begin
                tx_d   = 1'b1;
                baud_d = '0;
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    shift_d  = fifo_rd_data;
                    parity_d = parity_bit(8'(fifo_rd_data), PARITY);
                    state_d  = ST_START;
                    tx_d     = 1'b0;
                end
            end
            ST_START: begin
                if (bit_end) begin
                    baud_d  = '0;
                    bit_d   = '0;
                    state_d = ST_DATA;
                    tx_d    = shift_q[0];
                end
            end
            ST_DATA: begin
                if (bit_end) begin
                    baud_d = '0;
                    if (bit_q == BIT_W'(DATA_BITS - 1)) begin
                        bit_d = '0;
                        if (PARITY != PARITY_NONE) begin
                            state_d = ST_PARITY;
                            tx_d    = parity_q;
                        end else begin
                            state_d = ST_STOP;
                            tx_d    = 1'b1;
                        end
                    end else begin
                        bit_d   = bit_q + BIT_W'(1);
                        shift_d = shift_q >> 1;
                        tx_d    = shift_q[1];
                    end
                end
            end
            ST_PARITY: begin
                if (bit_end) begin
                    baud_d  = '0;
                    bit_d   = '0;
                    state_d = ST_STOP;
                    tx_d    = 1'b1;
                end
            end
            ST_STOP: begin
                if (bit_end) begin
                    baud_d = '0;
                    if (bit_q == BIT_W'(STOP_BITS - 1)) begin
                        bit_d  = '0;
                        done_d = 1'b1;
                        // Back-to-back frames: pop now so the start bit follows with no gap.
                        if (!fifo_empty) begin
                            fifo_pop = 1'b1;
                            shift_d  = fifo_rd_data;
                            parity_d = parity_bit(8'(fifo_rd_data), PARITY);
                            state_d  = ST_START;
                            tx_d     = 1'b0;
                        end else begin
                            state_d  = ST_IDLE;
                            tx_d     = 1'b1;
                        end
                    end else begin
                        bit_d = bit_q + BIT_W'(1);
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                baud_d  = '0;
                tx_d    = 1'b1;
            end
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q  <= ST_IDLE;
            baud_q   <= '0;
            bit_q    <= '0;
            shift_q  <= '0;
            parity_q <= 1'b0;
            tx_q     <= 1'b1;
            done_q   <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            baud_q   <= baud_d;
            bit_q    <= bit_d;
            shift_q  <= shift_d;
            parity_q <= parity_d;
            tx_q     <= tx_d;
            done_q   <= done_d;
            busy_q   <= busy_d;
        end
    end

endmodule

// File: tb/tb_uart_tx_param.sv
// tb/tb_uart_tx_param.sv - directed bench for uart_tx_param over several frame formats
module tb_uart_tx_param;

    logic       Clk = 1'b0;
    logic       Reset = 1'b1;
    logic [7:0] in_data = '0;
    logic [3:0] vld = '0;
    logic [3:0] rdy, tx, done, bsy;
    logic [2:0] lvl0, lvl1, lvl2;
    logic [4:0] lvl3;
    logic [1:0] sel = '0;

    int n_vec = 0;
    int n_err = 0;

    always #5 Clk = ~Clk;

    uart_tx_param #(.CLKS_PER_BIT(4), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4)) u_8n1 (
        .Clk(Clk), .Reset(Reset), .in_data(in_data), .in_valid(vld[0]), .in_ready(rdy[0]),
        .uart_tx(tx[0]), .busy(bsy[0]), .tx_done(done[0]), .fifo_level(lvl0));

    uart_tx_param #(.CLKS_PER_BIT(4), .DATA_BITS(7), .PARITY(1), .STOP_BITS(2), .FIFO_DEPTH(4)) u_7e2 (
        .Clk(Clk), .Reset(Reset), .in_data(in_data[6:0]), .in_valid(vld[1]), .in_ready(rdy[1]),
        .uart_tx(tx[1]), .busy(bsy[1]), .tx_done(done[1]), .fifo_level(lvl1));

    uart_tx_param #(.CLKS_PER_BIT(4), .DATA_BITS(7), .PARITY(2), .STOP_BITS(1), .FIFO_DEPTH(4)) u_7o1 (
        .Clk(Clk), .Reset(Reset), .in_data(in_data[6:0]), .in_valid(vld[2]), .in_ready(rdy[2]),
        .uart_tx(tx[2]), .busy(bsy[2]), .tx_done(done[2]), .fifo_level(lvl2));

    uart_tx_param u_def (
        .Clk(Clk), .Reset(Reset), .in_data(in_data), .in_valid(vld[3]), .in_ready(rdy[3]),
        .uart_tx(tx[3]), .busy(bsy[3]), .tx_done(done[3]), .fifo_level(lvl3));

    function automatic logic cur_tx();   return tx[sel];   endfunction
    function automatic logic cur_done(); return done[sel]; endfunction
    function automatic logic cur_busy(); return bsy[sel];  endfunction
    function automatic logic cur_rdy();  return rdy[sel];  endfunction
    function automatic logic [4:0] cur_lvl();
        case (sel)
            2'd0:    return 5'(lvl0);
            2'd1:    return 5'(lvl1);
            2'd2:    return 5'(lvl2);
            default: return lvl3;
        endcase
    endfunction

    typedef struct {
        logic [1:0]  sel;
        logic [7:0]  data;
        int          nbits;
        logic [15:0] frame;
    } vec_t;

    vec_t vecs[8];

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        vld   = '0;
        Reset = 1'b1;
        tick();
        tick();
        Reset = 1'b0;
    endtask

    task automatic push(input logic [1:0] s, input logic [7:0] d);
        in_data = d;
        vld     = 4'b0001 << s;
        tick();
        vld     = '0;
    endtask

    task automatic wait_start(input int limit, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < limit; i++) begin
            if (cur_tx() == 1'b0) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
    endtask

    initial begin
        bit          ok;
        int          bad;
        int          n;
        int          pulses;
        logic [9:0]  bf;
        logic [7:0]  bd [3];

        // Frame bits in transmission order, bit 0 = start bit.
        vecs[0] = '{2'd0, 8'hA5, 10, 16'h034A};
        vecs[1] = '{2'd0, 8'h3C, 10, 16'h0278};
        vecs[2] = '{2'd0, 8'h00, 10, 16'h0200};
        vecs[3] = '{2'd0, 8'hFF, 10, 16'h03FE};
        vecs[4] = '{2'd1, 8'h55, 11, 16'h06AA};
        vecs[5] = '{2'd2, 8'h55, 10, 16'h03AA};
        vecs[6] = '{2'd1, 8'h07, 11, 16'h070E};
        vecs[7] = '{2'd2, 8'h07, 10, 16'h020E};

        tick();
        tick();
        for (int s = 0; s < 4; s++) begin
            sel = 2'(s);
            check("reset_tx",    32'(cur_tx()),   32'd1);
            check("reset_done",  32'(cur_done()), 32'd0);
            check("reset_busy",  32'(cur_busy()), 32'd0);
            check("reset_level", 32'(cur_lvl()),  32'd0);
            check("reset_ready", 32'(cur_rdy()),  32'd1);
        end
        Reset = 1'b0;

        for (int v = 0; v < 8; v++) begin
            sel = vecs[v].sel;
            do_reset();
            push(vecs[v].sel, vecs[v].data);
            wait_start(20, ok);
            check("start_seen", 32'(ok), 32'd1);
            bad = 0;
            for (int c = 0; c < vecs[v].nbits * 4; c++) begin
                if (cur_tx() !== vecs[v].frame[c / 4]) bad++;
                if (cur_done() !== 1'b0) bad++;
                tick();
            end
            check("frame_bits", 32'(bad), 32'd0);
            check("tx_done_at_end", 32'(cur_done()), 32'd1);
            tick();
            check("tx_done_single", 32'(cur_done()), 32'd0);
            check("line_idle_after", 32'(cur_tx()), 32'd1);
        end

        // Burst of three words: contiguous frames, pulses at 40/80/120.
        sel = 2'd0;
        do_reset();
        bd[0] = 8'h11; bd[1] = 8'h22; bd[2] = 8'h33;
        in_data = bd[0]; vld = 4'b0001; tick();
        in_data = bd[1]; tick();
        in_data = bd[2];
        check("burst_start", 32'(cur_tx()), 32'd0);
        bad = 0;
        for (int c = 0; c < 120; c++) begin
            bf = {1'b1, bd[c / 40], 1'b0};
            if (cur_tx() !== bf[(c % 40) / 4]) bad++;
            if (cur_done() !== ((c == 40) || (c == 80))) bad++;
            if (cur_busy() !== 1'b1) bad++;
            tick();
            vld = '0;
        end
        check("burst_frames", 32'(bad), 32'd0);
        check("burst_done3", 32'(cur_done()), 32'd1);
        check("burst_busy_on_pulse", 32'(cur_busy()), 32'd1);
        tick();
        check("burst_busy_fall", 32'(cur_busy()), 32'd0);
        check("burst_done_clear", 32'(cur_done()), 32'd0);

        // Overfill a depth-4 FIFO while the first frame occupies the line.
        do_reset();
        for (int i = 0; i < 6; i++) begin
            in_data = 8'h40 + 8'(i);
            vld     = 4'b0001;
            tick();
            if (i == 1) check("push_pop_level", 32'(cur_lvl()), 32'd1);
            if (i >= 4) begin
                check("full_level", 32'(cur_lvl()), 32'd4);
                check("full_ready", 32'(cur_rdy()), 32'd0);
            end
        end
        vld = '0;
        pulses = 0;
        for (int c = 0; c < 300; c++) begin
            if (cur_done() === 1'b1) pulses++;
            tick();
        end
        check("full_frame_count", 32'(pulses), 32'd5);
        check("full_drained_level", 32'(cur_lvl()), 32'd0);
        check("full_drained_busy", 32'(cur_busy()), 32'd0);

        // Reset during data bit 3 aborts the frame and flushes the FIFO.
        do_reset();
        push(2'd0, 8'hA5);
        push(2'd0, 8'h3C);
        wait_start(20, ok);
        check("rst_start_seen", 32'(ok), 32'd1);
        for (int c = 0; c < 17; c++) tick();
        check("rst_bit3_value", 32'(cur_tx()), 32'd0);
        Reset = 1'b1;
        tick();
        check("rst_line_high", 32'(cur_tx()), 32'd1);
        check("rst_level", 32'(cur_lvl()), 32'd0);
        check("rst_done", 32'(cur_done()), 32'd0);
        Reset = 1'b0;
        pulses = 0;
        bad = 0;
        for (int c = 0; c < 60; c++) begin
            if (cur_done() !== 1'b0) pulses++;
            if (cur_tx() !== 1'b1) bad++;
            tick();
        end
        check("rst_no_done", 32'(pulses), 32'd0);
        check("rst_line_quiet", 32'(bad), 32'd0);

        // Default 50 MHz / 9600 baud: measure the start-bit width.
        sel = 2'd3;
        do_reset();
        push(2'd3, 8'h01);
        wait_start(20, ok);
        check("def_start_seen", 32'(ok), 32'd1);
        n = 0;
        while (cur_tx() == 1'b0 && n < 6000) begin
            n++;
            tick();
        end
        check("default_bit_period", 32'(n), 32'd5208);
        do_reset();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
